int_timer: RTL
==============

INT_TIMER -- requirements
Module: int_timer

Interface
REQ-001 The block SHALL have no parameters; all datapath widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 addr  input  2  register word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-005 we  input  1  bus write enable; write takes effect at the posedge where we=1.
REQ-006 din  input  32  bus write data.
REQ-007 dout  output  32  bus read data, combinational from addr.
REQ-008 irq  output  1  interrupt request to the CPU's hardware-interrupt line (drives one HWInt bit of CP0).

Function
REQ-009 CTRL SHALL hold 4 bits: [0] EN, [2:1] MODE, [3] IM; din[31:4] ignored on write; dout[31:4]=0 on read.
REQ-010 MODE SHALL be: 00 one-shot; 01 auto-reload; 1x behaves as 00 but reads back as written.
REQ-011 PRESET SHALL be a 32-bit read/write register; COUNT a 32-bit read-only register; writes to addr 2 or 3 SHALL be ignored; addr 3 reads 0.
REQ-012 FSM states SHALL be IDLE, LOAD, CNT, INT, each lasting at least one cycle.
REQ-013 IDLE: EN=1 -> LOAD next cycle; else stay; COUNT holds.
REQ-014 LOAD: COUNT <= PRESET; -> CNT.
REQ-015 CNT: EN=0 -> IDLE with COUNT held; else COUNT>1 -> COUNT <= COUNT-1, stay; else (COUNT 1 or 0) -> COUNT <= 0, -> INT.
REQ-016 INT: pending flag set; one-shot -> EN cleared, -> IDLE; auto-reload -> LOAD.
REQ-017 irq SHALL equal pending AND IM, registered (no combinational path from bus inputs).
REQ-018 One-shot: pending SHALL stay 1 until a write to CTRL or PRESET; that write clears it the same edge.
REQ-019 Auto-reload: pending SHALL be 1 for exactly one cycle per expiry (the cycle after INT).
REQ-020 Latency: with PRESET=N>=1 and EN set at edge t, INT is entered at edge t+N+2 (N=0 same as N=1); irq rises the cycle after INT.
REQ-021 Period in auto-reload with PRESET=N>=1 SHALL be N+2 cycles between irq pulses.
REQ-022 A PRESET write during CNT SHALL NOT alter COUNT; the new value is used at the next LOAD.
REQ-023 A CTRL write in the same cycle the FSM clears EN (one-shot INT) SHALL win: CTRL takes din[3:0].
REQ-024 Clearing IM SHALL mask irq immediately (next cycle) without clearing pending; re-setting IM re-exposes a held pending.
REQ-025 Writing EN=0 in any state SHALL halt at the next CNT evaluation; LOAD and INT complete their single cycle first.

Reset
REQ-026 On rst=1 at posedge: CTRL=0, PRESET=0, COUNT=0, pending=0, FSM=IDLE; irq=0 the following cycle.
REQ-027 rst SHALL take priority over any simultaneous bus write and over any FSM transition, including mid-count.

Verification
REQ-028 rst; write PRESET=5, CTRL=0x9 (EN,IM,one-shot) -> COUNT reads 5,4,3,2,1,0; irq=1 held; CTRL reads 0x8; irq drops after write CTRL=0x8.
REQ-029 PRESET=3, CTRL=0xB (auto-reload, IM) -> irq one-cycle pulses every 5 cycles; COUNT sequence 3,2,1,0 repeating.
REQ-030 PRESET=10, CTRL=0x1 (IM=0) -> irq stays 0 at expiry; then write CTRL... no: set IM via CTRL=0x8 write clears pending -> irq 0; verify masked-then-unmasked case with PRESET rewrite absent.
REQ-031 During count with COUNT=6, write PRESET=2 -> COUNT continues 5,4...; auto-reload next LOAD gives 2.
REQ-032 Write CTRL=0 while COUNT=7 -> COUNT freezes at 6 or 7 per REQ-015; rewrite CTRL=0x9 -> LOAD reloads PRESET.
REQ-033 Assert rst while COUNT=4 with simultaneous we to PRESET=0xFF -> all registers 0, irq 0, FSM IDLE.

Source files
------------

// File: rtl/int_timer.sv
// ---------------------------------------------------------------------------
// int_timer
//
// Memory-mapped 32-bit down-counting interval timer with an interrupt output.
// Software loads a reload value (PRESET), selects a mode and enables the
// timer through CTRL. The timer copies PRESET into COUNT and counts down to
// zero. On expiry it raises a pending flag, which is exported as irq when the
// interrupt mask bit allows it.
//
// Register map (word select on addr):
//   0  CTRL    [0] EN, [2:1] MODE, [3] IM      (read/write, [31:4] read as 0)
//   1  PRESET  32-bit reload value             (read/write)
//   2  COUNT   32-bit current count            (read-only)
//   3  --      reads 0, writes ignored
//
// MODE: 00 one-shot, 01 auto-reload, 1x behaves as one-shot but reads back
// as written.
//
// Ports:
//   clk   in   1   single clock, all state changes on its rising edge
//   rst   in   1   synchronous, active-high reset
//   addr  in   2   register word select
//   we    in   1   bus write enable, write lands on the edge where we=1
//   din   in  32   bus write data
//   dout  out 32   bus read data, combinational from addr and register state
//   irq   out  1   registered interrupt request (pending AND IM)
// ---------------------------------------------------------------------------
module int_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Register word addresses
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // Only this exact MODE value reloads; 1x falls back to one-shot.
    localparam logic [1:0] MODE_AUTO = 2'b01;

    // Architectural state
    logic [1:0]  r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_pending;
    logic        r_irq;

    // Next-state values
    logic [1:0]  w_state_next;
    logic [31:0] w_count_next;
    logic        w_fsm_clr_en;
    logic        w_en_next;
    logic [1:0]  w_mode_next;
    logic        w_im_next;
    logic [31:0] w_preset_next;
    logic        w_pending_next;
    logic        w_irq_next;

    // Bus decode
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_auto;

    assign w_wr_ctrl   = we && (addr == ADDR_CTRL);
    assign w_wr_preset = we && (addr == ADDR_PRESET);
    assign w_auto      = (r_mode == MODE_AUTO);

    // -----------------------------------------------------------------------
    // Counter FSM
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        w_state_next = r_state;
        w_count_next = r_count;
        w_fsm_clr_en = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_en) begin
                    w_state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_count_next = r_preset;
                w_state_next = ST_CNT;
            end

            ST_CNT: begin
                // EN is only honoured here, so LOAD and INT always finish
                // their single cycle even if software has just cleared EN.
                if (!r_en) begin
                    w_state_next = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_next = r_count - 32'd1;
                end else begin
                    // A PRESET of 0 expires exactly like a PRESET of 1.
                    w_count_next = 32'd0;
                    w_state_next = ST_INT;
                end
            end

            ST_INT: begin
                if (w_auto) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_fsm_clr_en = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Bus-visible register updates
    // -----------------------------------------------------------------------
    always_comb begin
        // A software write to CTRL overrides the FSM's one-shot EN clear
        // landing on the same edge.
        if (w_wr_ctrl) begin
            w_en_next   = din[0];
            w_mode_next = din[2:1];
            w_im_next   = din[3];
        end else begin
            w_en_next   = r_en & ~w_fsm_clr_en;
            w_mode_next = r_mode;
            w_im_next   = r_im;
        end

        // PRESET never touches COUNT directly; it is only sampled at LOAD.
        w_preset_next = w_wr_preset ? din : r_preset;
    end

    // -----------------------------------------------------------------------
    // Pending flag and interrupt
    // -----------------------------------------------------------------------
    always_comb begin
        if (r_state == ST_INT) begin
            w_pending_next = 1'b1;
        end else if (w_auto) begin
            // Auto-reload: pending lives for exactly the cycle after INT.
            w_pending_next = 1'b0;
        end else if (w_wr_ctrl || w_wr_preset) begin
            // One-shot: held until software touches CTRL or PRESET.
            w_pending_next = 1'b0;
        end else begin
            w_pending_next = r_pending;
        end

        // irq is registered from the next-state values so it rises in the
        // same cycle pending becomes visible, while still having no
        // combinational path from the bus to the output pin.
        w_irq_next = w_pending_next & w_im_next;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'b00;
            r_im      <= 1'b0;
            r_preset  <= 32'd0;
            r_count   <= 32'd0;
            r_pending <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_en      <= w_en_next;
            r_mode    <= w_mode_next;
            r_im      <= w_im_next;
            r_preset  <= w_preset_next;
            r_count   <= w_count_next;
            r_pending <= w_pending_next;
            r_irq     <= w_irq_next;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        case (addr)
            ADDR_CTRL:   dout = {28'd0, r_im, r_mode, r_en};
            ADDR_PRESET: dout = r_preset;
            ADDR_COUNT:  dout = r_count;
            default:     dout = 32'd0;
        endcase
    end

    assign irq = r_irq;

endmodule
